// File: rtl/life_pkg.sv
// Shared state encoding, life-counter width and default game parameters for the life controller.
package life_pkg;
  localparam int LIFE_W            = 4;
  localparam int DEF_MAX_LIFE      = 4;
  localparam int DEF_INVULN_FRAMES = 60;
  localparam int DEF_BLINK_FRAMES  = 8;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_ALIVE     = 2'd1;
  localparam state_t ST_INVULN    = 2'd2;
  localparam state_t ST_GAME_OVER = 2'd3;
endpackage

// File: rtl/life_controller_if.sv
// Event inputs and status outputs of the life controller; slave = controller side.
interface life_controller_if;
  import life_pkg::*;
  logic              i_Start;
  logic              i_Hit;
  logic              i_Extra_Life;
  logic              i_Frame_Tick;
  logic [LIFE_W-1:0] o_Life;
  logic              o_Game_Over;
  logic              o_Invuln;
  logic              o_Life_Visible;

  modport slave  (input  i_Start, i_Hit, i_Extra_Life, i_Frame_Tick,
                  output o_Life, o_Game_Over, o_Invuln, o_Life_Visible);
  modport master (output i_Start, i_Hit, i_Extra_Life, i_Frame_Tick,
                  input  o_Life, o_Game_Over, o_Invuln, o_Life_Visible);
endinterface

// File: rtl/life_frame_timer.sv
// Frame-tick down-counter with clear, load and terminal detect (tick arriving while count==1).
module life_frame_timer #(
  parameter int W = 8
) (
  input  logic         i_Clk,
  input  logic         i_Reset,
  input  logic         i_Clear,
  input  logic         i_Load,
  input  logic [W-1:0] i_Load_Val,
  input  logic         i_Tick,
  output logic         o_Expire
);
  logic [W-1:0] r_Count;

  assign o_Expire = i_Tick && (r_Count == W'(1));

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset)
      r_Count <= '0;
    else if (i_Clear)
      r_Count <= '0;
    else if (i_Load)
      r_Count <= i_Load_Val;
    else if (i_Tick && (r_Count != '0))
      r_Count <= r_Count - W'(1);
  end
endmodule

// File: rtl/life_controller.sv
// Player life/invulnerability FSM. Define LIFE_BLINK_EN to blink the life display while invulnerable.
module life_controller
  import life_pkg::*;
#(
  parameter int MAX_LIFE      = DEF_MAX_LIFE,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int BLINK_FRAMES  = DEF_BLINK_FRAMES
) (
  input  logic               i_Clk,
  input  logic               i_Reset,
  life_controller_if.slave   bus
);
  localparam logic [LIFE_W-1:0] MAX_L = LIFE_W'(MAX_LIFE);

  state_t            r_State;
  logic [LIFE_W-1:0] r_Life;
  logic              r_Game_Over;
  logic              r_Invuln;
  state_t            w_Next_State;
  logic [LIFE_W-1:0] w_Next_Life;
  logic              w_Inv_Load;
  logic              w_Inv_Tick;
  logic              w_Inv_Expire;
  logic              w_Ev_Tick;

  // Frame ticks only matter while invulnerable, and i_Start overrides them
  assign w_Ev_Tick = (r_State == ST_INVULN) && bus.i_Frame_Tick && !bus.i_Start;

  always_comb begin
    w_Next_State = r_State;
    w_Next_Life  = r_Life;
    w_Inv_Load   = 1'b0;
    w_Inv_Tick   = 1'b0;
    if (bus.i_Start) begin
      w_Next_State = ST_ALIVE;
      w_Next_Life  = MAX_L;
    end else begin
      case (r_State)
        ST_ALIVE: begin
          if (bus.i_Hit) begin
            if (r_Life > LIFE_W'(1)) begin
              w_Next_Life  = r_Life - LIFE_W'(1);
              w_Inv_Load   = 1'b1;
              w_Next_State = ST_INVULN;
            end else begin
              w_Next_Life  = '0;
              w_Next_State = ST_GAME_OVER;
            end
          end else if (bus.i_Extra_Life && (r_Life < MAX_L)) begin
            w_Next_Life = r_Life + LIFE_W'(1);
          end
        end
        ST_INVULN: begin
          if (bus.i_Extra_Life && (r_Life < MAX_L))
            w_Next_Life = r_Life + LIFE_W'(1);
          if (bus.i_Frame_Tick) begin
            w_Inv_Tick = 1'b1;
            if (w_Inv_Expire)
              w_Next_State = ST_ALIVE;
          end
        end
        default: ;
      endcase
    end
  end

  life_frame_timer #(.W(8)) u_inv_timer (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Clear    (bus.i_Start),
    .i_Load     (w_Inv_Load),
    .i_Load_Val (8'(INVULN_FRAMES)),
    .i_Tick     (w_Inv_Tick),
    .o_Expire   (w_Inv_Expire)
  );

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State     <= ST_IDLE;
      r_Life      <= '0;
      r_Game_Over <= 1'b0;
      r_Invuln    <= 1'b0;
    end else begin
      r_State     <= w_Next_State;
      r_Life      <= w_Next_Life;
      r_Game_Over <= (w_Next_State == ST_GAME_OVER);
      r_Invuln    <= (w_Next_State == ST_INVULN);
    end
  end

  assign bus.o_Life      = r_Life;
  assign bus.o_Game_Over = r_Game_Over;
  assign bus.o_Invuln    = r_Invuln;

`ifdef LIFE_BLINK_EN
  logic w_Blink_Expire;
  logic w_Blink_Load;
  logic r_Visible;

  // Reload the half-period on INVULN entry and at every toggle
  assign w_Blink_Load = w_Inv_Load || (w_Ev_Tick && w_Blink_Expire);

  life_frame_timer #(.W(8)) u_blink_timer (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Clear    (bus.i_Start),
    .i_Load     (w_Blink_Load),
    .i_Load_Val (8'(BLINK_FRAMES)),
    .i_Tick     (w_Ev_Tick),
    .o_Expire   (w_Blink_Expire)
  );

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset)
      r_Visible <= 1'b1;
    else if ((w_Next_State != ST_INVULN) || w_Inv_Load)
      r_Visible <= 1'b1;
    else if (w_Ev_Tick && w_Blink_Expire)
      r_Visible <= ~r_Visible;
  end

  assign bus.o_Life_Visible = r_Visible;
`else
  assign bus.o_Life_Visible = 1'b1;
`endif
endmodule

// File: tb/tb_life_controller.sv
// Directed bench for life_controller; blink expectations follow LIFE_BLINK_EN.
module tb_life_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_pass  = 0;
  int   ticks   = 0;

  life_controller_if bus();

  life_controller u_dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, act, exp);
  endtask

  function automatic int exp_vis(input int t);
`ifdef LIFE_BLINK_EN
    return ((t / 8) % 2 == 0) ? 1 : 0;
`else
    return 1;
`endif
  endfunction

  // One event cycle: drive at negedge, release and sample 1 time unit after posedge
  task automatic pulse(input bit s, input bit h, input bit x, input bit f);
    @(negedge clk);
    bus.i_Start = s; bus.i_Hit = h; bus.i_Extra_Life = x; bus.i_Frame_Tick = f;
    @(posedge clk);
    #1;
    bus.i_Start = 0; bus.i_Hit = 0; bus.i_Extra_Life = 0; bus.i_Frame_Tick = 0;
  endtask

  task automatic run_ticks(input int n);
    for (int k = 0; k < n; k++) pulse(0, 0, 0, 1);
  endtask

  initial begin
    bus.i_Start = 0; bus.i_Hit = 0; bus.i_Extra_Life = 0; bus.i_Frame_Tick = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_life", bus.o_Life, 0);
    check("rst_go",   bus.o_Game_Over, 0);
    check("rst_inv",  bus.o_Invuln, 0);
    check("rst_vis",  bus.o_Life_Visible, 1);
    @(negedge clk); rst = 0;

    pulse(0, 1, 1, 1);
    check("idle_ignore", bus.o_Life, 0);

    pulse(1, 0, 0, 0);
    check("start_life", bus.o_Life, 4);
    check("start_go",   bus.o_Game_Over, 0);
    check("start_inv",  bus.o_Invuln, 0);

    pulse(0, 0, 1, 0);
    check("extra_sat", bus.o_Life, 4);

    pulse(0, 1, 0, 0);
    check("hit_life", bus.o_Life, 3);
    check("hit_inv",  bus.o_Invuln, 1);
    check("hit_vis",  bus.o_Life_Visible, 1);

    ticks = 0;
    for (int t = 1; t <= 59; t++) begin
      pulse(0, 0, 0, 1);
      ticks = t;
      if (t == 7 || t == 8 || t == 15 || t == 16 || t == 56)
        check($sformatf("vis_t%0d", t), bus.o_Life_Visible, exp_vis(t));
      if (t == 10) begin
        pulse(0, 1, 0, 0);
        check("inv_hit_ignored", bus.o_Life, 3);
      end
      if (t == 20) begin
        pulse(0, 0, 1, 0);
        check("inv_extra", bus.o_Life, 4);
      end
    end
    check("inv_t59", bus.o_Invuln, 1);
    pulse(0, 0, 0, 1);
    check("inv_t60",  bus.o_Invuln, 0);
    check("vis_exit", bus.o_Life_Visible, 1);

    pulse(0, 1, 0, 0);
    check("hit2_life", bus.o_Life, 3);
    run_ticks(60);
    pulse(0, 1, 0, 0);
    check("hit3_life", bus.o_Life, 2);
    run_ticks(60);
    check("alive_again", bus.o_Invuln, 0);

    pulse(0, 1, 1, 0);
    check("hit_x_life", bus.o_Life, 1);
    check("hit_x_inv",  bus.o_Invuln, 1);
    run_ticks(60);

    pulse(0, 1, 0, 0);
    check("fatal_life", bus.o_Life, 0);
    check("fatal_go",   bus.o_Game_Over, 1);
    check("fatal_inv",  bus.o_Invuln, 0);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 1, 1);
    check("go_life", bus.o_Life, 0);
    check("go_hold", bus.o_Game_Over, 1);
    pulse(1, 0, 0, 0);
    check("restart_life", bus.o_Life, 4);
    check("restart_go",   bus.o_Game_Over, 0);

    pulse(1, 1, 1, 1);
    check("start_ovr_life", bus.o_Life, 4);
    check("start_ovr_inv",  bus.o_Invuln, 0);

    pulse(0, 1, 0, 0);
    run_ticks(9);
    check("pre_rst_inv", bus.o_Invuln, 1);
    @(negedge clk);
    #2 rst = 1;
    #1;
    check("arst_life", bus.o_Life, 0);
    check("arst_inv",  bus.o_Invuln, 0);
    check("arst_go",   bus.o_Game_Over, 0);
    check("arst_vis",  bus.o_Life_Visible, 1);
    @(posedge clk);
    @(negedge clk); rst = 0;
    pulse(0, 1, 1, 1);
    check("post_rst_idle", bus.o_Life, 0);
    pulse(1, 0, 0, 0);
    check("post_rst_start", bus.o_Life, 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1, want 0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/life_controller.md
LIFE_CONTROLLER -- requirements
Module: life_controller

Interface
REQ-001 SHALL have parameter MAX_LIFE, default 4: lives loaded at game start and the add-life ceiling; legal range 1..15.
REQ-002 SHALL have parameter INVULN_FRAMES, default 60: frame ticks of invulnerability after a non-fatal hit; legal range 2..255.
REQ-003 SHALL have parameter BLINK_FRAMES, default 8: frame ticks per blink half-period; legal range 1..INVULN_FRAMES.
REQ-004 Ports, in this order:
- i_Clk  in  1  system clock; one clock domain.
- i_Reset  in  1  reset, asynchronous, active-high.
- i_Start  in  1  single-cycle pulse that starts a new game.
- i_Hit  in  1  single-cycle pulse: player damaged.
- i_Extra_Life  in  1  single-cycle pulse: grant one life.
- i_Frame_Tick  in  1  single-cycle pulse, once per video frame.
- o_Life  out  4  current life count, feeding the life display.
- o_Game_Over  out  1  high while in GAME_OVER.
- o_Invuln  out  1  high while in INVULN.
- o_Life_Visible  out  1  display enable for the life squares.

Function
REQ-005 SHALL implement states IDLE, ALIVE, INVULN and GAME_OVER; all outputs registered; every event is reflected on the outputs on the clock edge after it is sampled (latency 1).
REQ-006 i_Start in any state SHALL load o_Life=MAX_LIFE, clear the invulnerability counter and enter ALIVE; i_Start overrides i_Hit, i_Extra_Life and i_Frame_Tick in the same cycle.
REQ-007 IDLE and GAME_OVER SHALL ignore i_Hit, i_Extra_Life and i_Frame_Tick.
REQ-008 ALIVE + i_Hit with o_Life>1 SHALL decrement o_Life, load counter=INVULN_FRAMES and enter INVULN.
REQ-009 ALIVE + i_Hit with o_Life==1 SHALL set o_Life=0 and enter GAME_OVER.
REQ-010 INVULN SHALL ignore i_Hit.
REQ-011 INVULN + i_Frame_Tick SHALL decrement the counter; a tick with counter==1 SHALL enter ALIVE with counter=0.
REQ-012 i_Extra_Life in ALIVE or INVULN SHALL increment o_Life, saturating at MAX_LIFE with no wrap.
REQ-013 ALIVE + i_Hit + i_Extra_Life in the same cycle: the hit SHALL take priority and the extra life SHALL be dropped.
REQ-014 o_Life SHALL never exceed MAX_LIFE and SHALL never underflow below 0.
REQ-015 o_Game_Over SHALL equal (state==GAME_OVER); o_Invuln SHALL equal (state==INVULN).

Reset
REQ-016 Reset SHALL take effect asynchronously: state=IDLE, o_Life=0, counter=0, blink divider=0, o_Game_Over=0, o_Invuln=0, o_Life_Visible=1.
REQ-017 Reset asserted mid-INVULN or in GAME_OVER SHALL discard all progress; no event is accepted until the first clock edge after reset deasserts.

Configuration
REQ-018 With macro LIFE_BLINK_EN defined: in INVULN, o_Life_Visible SHALL toggle every BLINK_FRAMES frame ticks, starting at 1 on INVULN entry; in all other states it SHALL be 1.
REQ-019 Without LIFE_BLINK_EN: o_Life_Visible SHALL be constant 1 and no blink divider logic SHALL be synthesized.

Structure
REQ-020 Package life_pkg SHALL hold the state encoding typedef, the life-width constant (4), and the default MAX_LIFE, INVULN_FRAMES and BLINK_FRAMES values.
REQ-021 The frame-tick down-counter with load and zero-detect SHALL be the sub-module life_frame_timer, instantiated once for invulnerability and, under LIFE_BLINK_EN, once for blink.

Verification
REQ-022 Reset, then i_Start -> next cycle o_Life=4, ALIVE, o_Game_Over=0, o_Invuln=0.
REQ-023 In ALIVE, i_Hit -> o_Life=3, o_Invuln=1; 59 frame ticks leave o_Invuln=1; the 60th tick gives o_Invuln=0; an i_Hit during INVULN leaves o_Life=3.
REQ-024 From o_Life=1 in ALIVE, i_Hit -> o_Life=0, o_Game_Over=1; further i_Hit/i_Extra_Life make no change; i_Start -> o_Life=4, o_Game_Over=0.
REQ-025 At o_Life=4, i_Extra_Life -> o_Life stays 4; at o_Life=2 in ALIVE, i_Hit and i_Extra_Life in the same cycle -> o_Life=1, INVULN.
REQ-026 LIFE_BLINK_EN, BLINK_FRAMES=8: after a hit, o_Life_Visible is 1 for ticks 1-7, 0 from tick 8, 1 from tick 16, and 1 after INVULN exit; without the macro it is always 1.
REQ-027 Assert i_Reset asynchronously mid-INVULN (between edges) -> outputs take reset values immediately, before the next clock edge.
